// File: rtl/cordic_pkg.sv
// Shared constants and the result record for the CORDIC post stage.
// Angles are unsigned 9.8 fixed point in degrees.
package cordic_pkg;
    localparam int UOUT_W       = 16;
    localparam int UOUT_FRAC_W  = 8;
    localparam int SECTOR_W     = 2;
    localparam int PIPE_LAT     = 7;
    localparam int RES_W        = 17;
    localparam int RES_FIFO_DEP = 4;

    localparam logic [SECTOR_W-1:0] SECTOR_Q1 = 2'd0;
    localparam logic [SECTOR_W-1:0] SECTOR_Q2 = 2'd1;
    localparam logic [SECTOR_W-1:0] SECTOR_Q3 = 2'd2;
    localparam logic [SECTOR_W-1:0] SECTOR_Q4 = 2'd3;

    localparam logic [RES_W:0] ANGLE_90  = 18'd23040;
    localparam logic [RES_W:0] ANGLE_360 = 18'd92160;

    typedef struct packed {
        logic             mode;
        logic [RES_W-1:0] angle;
        logic [RES_W-1:0] y;
        logic [RES_W-1:0] x;
    } cordic_res_t;

    localparam int RES_REC_W = $bits(cordic_res_t);
endpackage

// File: rtl/cordic_result_fifo.sv
// Show-ahead result FIFO with valid/ready read side and occupancy count.
// Head data reads as zero while empty so stale storage never leaks out.
module cordic_result_fifo #(
    parameter int WIDTH = 52,
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [LVL_W-1:0] level_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             rd_fire, wr_fire;

    assign empty_o    = (level_q == '0);
    assign full_o     = (level_q == LVL_W'(DEPTH));
    assign rd_valid_o = ~empty_o;
    assign rd_data_o  = empty_o ? '0 : mem_q[rptr_q];
    assign level_o    = level_q;

    // A read in the same cycle frees the slot, so a full FIFO can still accept.
    assign rd_fire = rd_valid_o & rd_ready_i;
    assign wr_fire = wr_en_i & (~full_o | rd_fire);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (wr_fire) wptr_d = wptr_q + 1'b1;
        if (rd_fire) rptr_d = rptr_q + 1'b1;
        if (wr_fire && !rd_fire)      level_d = level_q + 1'b1;
        else if (!wr_fire && rd_fire) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) mem_q[wptr_q] <= wr_data_i;
    end
endmodule

// File: rtl/cordic_post_stage.sv
// CORDIC post stage: valid tracking, quadrant unfolding, one recon register,
// and a result FIFO with a sticky drop flag.
module cordic_post_stage
    import cordic_pkg::*;
#(
    parameter int UNSIGNED_OUTPUT_WIDTH      = UOUT_W,
    parameter int UNSIGNED_OUTPUT_FRAC_WIDTH = UOUT_FRAC_W,
    parameter int SECTOR_FLAG_WIDTH          = SECTOR_W,
    parameter int PIPE_LATENCY               = PIPE_LAT,
    parameter int RESULT_WIDTH               = RES_W,
    parameter int FIFO_DEPTH                 = RES_FIFO_DEP
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             valid_in,
    input  logic [UNSIGNED_OUTPUT_WIDTH-1:0] degree_out,
    input  logic [UNSIGNED_OUTPUT_WIDTH-1:0] x_out,
    input  logic [UNSIGNED_OUTPUT_WIDTH-1:0] y_out,
    input  logic [SECTOR_FLAG_WIDTH-1:0]     sector_out,
    input  logic                             arctan_en_out,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [RESULT_WIDTH-1:0]          res_x,
    output logic [RESULT_WIDTH-1:0]          res_y,
    output logic [RESULT_WIDTH-1:0]          res_angle,
    output logic                             res_mode,
    output logic                             overflow,
    output logic [$clog2(FIFO_DEPTH):0]      level
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [RESULT_WIDTH:0] A90  = (RESULT_WIDTH+1)'(90) << UNSIGNED_OUTPUT_FRAC_WIDTH;
    localparam logic [RESULT_WIDTH:0] A180 = A90 << 1;
    localparam logic [RESULT_WIDTH:0] A270 = A90 + A180;
    localparam logic [RESULT_WIDTH:0] A360 = A90 << 2;

    logic [PIPE_LATENCY-1:0] vld_q;
    logic                    v_d;
    logic                    rv_q;
    cordic_res_t             rec_q, rec_d;

    logic [RESULT_WIDTH-1:0] x_ext, y_ext, rx, ry;
    logic [RESULT_WIDTH:0]   ofs, ang_sum, ang_wrap;

    logic             fifo_full, fifo_empty, rd_fire;
    cordic_res_t      head;
    logic [LVL_W-1:0] fifo_level;
    logic             overflow_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) vld_q <= '0;
        else        vld_q <= {vld_q[PIPE_LATENCY-2:0], valid_in};
    end
    assign v_d = vld_q[PIPE_LATENCY-1];

    always_comb begin
        x_ext = RESULT_WIDTH'(x_out);
        y_ext = RESULT_WIDTH'(y_out);
        rx    = x_ext;
        ry    = y_ext;
        ofs   = '0;
        case (sector_out)
            SECTOR_Q1: begin rx = x_ext;  ry = y_ext;  ofs = '0;   end
            SECTOR_Q2: begin rx = -y_ext; ry = x_ext;  ofs = A90;  end
            SECTOR_Q3: begin rx = -x_ext; ry = -y_ext; ofs = A180; end
            default:   begin rx = y_ext;  ry = -x_ext; ofs = A270; end
        endcase
        // Vectoring results are rotation invariant; only the angle is unfolded.
        if (arctan_en_out) begin
            rx = x_ext;
            ry = y_ext;
        end
        ang_sum  = (RESULT_WIDTH+1)'(degree_out) + ofs;
        ang_wrap = (ang_sum >= A360) ? ang_sum - A360 : ang_sum;

        rec_d       = '0;
        rec_d.x     = rx;
        rec_d.y     = ry;
        rec_d.angle = ang_wrap[RESULT_WIDTH-1:0];
        rec_d.mode  = arctan_en_out;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rv_q  <= 1'b0;
            rec_q <= '0;
        end else begin
            rv_q <= v_d;
            if (v_d) rec_q <= rec_d;
        end
    end

    cordic_result_fifo #(
        .WIDTH (RES_REC_W),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk_i      (clk),
        .rst_ni     (reset),
        .wr_en_i    (rv_q),
        .wr_data_i  (rec_q),
        .rd_valid_o (res_valid),
        .rd_ready_i (res_ready),
        .rd_data_o  (head),
        .level_o    (fifo_level),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign rd_fire = res_valid & res_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                               overflow_q <= 1'b0;
        else if (rv_q && fifo_full && !rd_fire)   overflow_q <= 1'b1;
    end

    assign res_x     = head.x;
    assign res_y     = head.y;
    assign res_angle = head.angle;
    assign res_mode  = head.mode & ~fifo_empty;
    assign overflow  = overflow_q;
    assign level     = fifo_level;
endmodule

// File: tb/tb_cordic_post_stage.sv
// Directed bench for cordic_post_stage; a 7-deep stimulus delay models the
// upstream CORDIC pipeline so outputs line up with the delayed valid.
module tb_cordic_post_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [15:0] degree_out, x_out, y_out;
    logic [1:0]  sector_out;
    logic        arctan_en_out;
    logic        res_valid, res_ready;
    logic [16:0] res_x, res_y, res_angle;
    logic        res_mode, overflow;
    logic [2:0]  level;

    int checks = 0;
    int errors = 0;

    logic [15:0] s_x, s_y, s_deg;
    logic [1:0]  s_sec;
    logic        s_mode;
    logic [15:0] p_x [7];
    logic [15:0] p_y [7];
    logic [15:0] p_deg [7];
    logic [1:0]  p_sec [7];
    logic        p_mode [7];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        p_x[0] <= s_x; p_y[0] <= s_y; p_deg[0] <= s_deg; p_sec[0] <= s_sec; p_mode[0] <= s_mode;
        for (int i = 1; i < 7; i++) begin
            p_x[i] <= p_x[i-1]; p_y[i] <= p_y[i-1]; p_deg[i] <= p_deg[i-1];
            p_sec[i] <= p_sec[i-1]; p_mode[i] <= p_mode[i-1];
        end
    end
    assign x_out         = p_x[6];
    assign y_out         = p_y[6];
    assign degree_out    = p_deg[6];
    assign sector_out    = p_sec[6];
    assign arctan_en_out = p_mode[6];

    cordic_post_stage dut (
        .clk           (clk),
        .reset         (reset),
        .valid_in      (valid_in),
        .degree_out    (degree_out),
        .x_out         (x_out),
        .y_out         (y_out),
        .sector_out    (sector_out),
        .arctan_en_out (arctan_en_out),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_x         (res_x),
        .res_y         (res_y),
        .res_angle     (res_angle),
        .res_mode      (res_mode),
        .overflow      (overflow),
        .level         (level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] deg,
                        input logic [1:0] sec, input logic mode);
        s_x = x; s_y = y; s_deg = deg; s_sec = sec; s_mode = mode;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic wait_level(input string tag, input logic [2:0] n);
        for (int k = 0; k < 30; k++) begin
            if (level == n) break;
            tick();
        end
        chk(tag, 32'(level), 32'(n));
    endtask

    task automatic pop();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; valid_in = 1'b0; res_ready = 1'b0;
        s_x = '0; s_y = '0; s_deg = '0; s_sec = '0; s_mode = 1'b0;
        @(negedge clk);
        tick();
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_x", 32'(res_x), 32'd0);
        chk("rst_angle", 32'(res_angle), 32'd0);
        reset = 1'b1;
        repeat (10) tick();

        // Q1 with exact latency: not valid after 8 edges, valid after 9.
        send(16'h00DD, 16'h0080, 16'h1E00, 2'b00, 1'b0);
        repeat (7) tick();
        chk("q1_early", 32'(res_valid), 32'd0);
        tick();
        chk("q1_valid", 32'(res_valid), 32'd1);
        chk("q1_x", 32'(res_x), 32'h000DD);
        chk("q1_y", 32'(res_y), 32'h00080);
        chk("q1_angle", 32'(res_angle), 32'h01E00);
        chk("q1_mode", 32'(res_mode), 32'd0);
        pop();
        chk("q1_drained", 32'(level), 32'd0);

        send(16'h00DD, 16'h0080, 16'h1E00, 2'b01, 1'b0);
        wait_level("q2_level", 3'd1);
        chk("q2_x", 32'(res_x), 32'h1FF80);
        chk("q2_y", 32'(res_y), 32'h000DD);
        chk("q2_angle", 32'(res_angle), 32'h07800);
        pop();

        send(16'h0010, 16'h0001, 16'h0100, 2'b10, 1'b0);
        wait_level("q3_level", 3'd1);
        chk("q3_x", 32'(res_x), 32'h1FFF0);
        chk("q3_y", 32'(res_y), 32'h1FFFF);
        chk("q3_angle", 32'(res_angle), 32'h0B500);
        pop();

        send(16'h0040, 16'h0020, 16'h0A00, 2'b11, 1'b0);
        wait_level("q4_level", 3'd1);
        chk("q4_x", 32'(res_x), 32'h00020);
        chk("q4_y", 32'(res_y), 32'h1FFC0);
        chk("q4_angle", 32'(res_angle), 32'h11800);
        pop();

        send(16'h0100, 16'h0003, 16'h1E00, 2'b10, 1'b1);
        wait_level("atan_level", 3'd1);
        chk("atan_x", 32'(res_x), 32'h00100);
        chk("atan_y", 32'(res_y), 32'h00003);
        chk("atan_angle", 32'(res_angle), 32'h0D200);
        chk("atan_mode", 32'(res_mode), 32'd1);
        pop();

        send(16'h0100, 16'h0000, 16'h5A00, 2'b11, 1'b1);
        wait_level("wrap_level", 3'd1);
        chk("wrap_angle", 32'(res_angle), 32'h00000);
        chk("wrap_valid", 32'(res_valid), 32'd1);
        pop();
        res_ready = 1'b1;
        tick();
        chk("empty_read", 32'(level), 32'd0);
        res_ready = 1'b0;

        // Backpressure: six samples, four fit, five and six are dropped.
        for (int i = 1; i <= 6; i++) send(16'(i), 16'h0000, 16'h0000, 2'b00, 1'b0);
        wait_level("bp_full", 3'd4);
        chk("bp_no_ovf_yet", 32'(overflow), 32'd0);
        tick();
        chk("bp_ovf", 32'(overflow), 32'd1);
        chk("bp_level", 32'(level), 32'd4);
        repeat (3) tick();
        chk("bp_head", 32'(res_x), 32'd1);
        res_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("bp_drain_valid", 32'(res_valid), 32'd1);
            chk("bp_drain_x", 32'(res_x), 32'(i));
            tick();
        end
        res_ready = 1'b0;
        chk("bp_empty", 32'(level), 32'd0);
        chk("bp_novalid", 32'(res_valid), 32'd0);
        chk("bp_ovf_sticky", 32'(overflow), 32'd1);

        // Reset mid-flight: three queued, two in the delay line.
        for (int i = 1; i <= 3; i++) send(16'(32 + i), 16'h0000, 16'h0000, 2'b00, 1'b0);
        wait_level("mf_queued", 3'd3);
        send(16'h0024, 16'h0000, 16'h0000, 2'b00, 1'b0);
        send(16'h0025, 16'h0000, 16'h0000, 2'b00, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        chk("mf_valid", 32'(res_valid), 32'd0);
        chk("mf_level", 32'(level), 32'd0);
        chk("mf_ovf", 32'(overflow), 32'd0);
        chk("mf_x", 32'(res_x), 32'd0);
        @(negedge clk);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 15; k++) begin
            chk("mf_quiet", 32'(res_valid), 32'd0);
            tick();
        end

        // Full FIFO with simultaneous read and write keeps level at four.
        for (int i = 1; i <= 5; i++) send(16'(16 + i), 16'h0000, 16'h0000, 2'b00, 1'b0);
        wait_level("rw_full", 3'd4);
        pop();
        chk("rw_level", 32'(level), 32'd4);
        chk("rw_ovf", 32'(overflow), 32'd0);
        res_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            chk("rw_drain_x", 32'(res_x), 32'(16 + i));
            tick();
        end
        res_ready = 1'b0;
        chk("rw_empty", 32'(level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
